mem_access_unit: RTL and testbench

Load/store front end for the data RAM in the RISC-V core. Takes one byte, halfword or word request at a time from the execute stage over a valid/ready handshake and drives the word-wide, single-write-port RAM (10-bit word address, 32-bit data, combinational read). Sub-word stores run as a read-modify-write sequence. Returns extended load data or a misalignment flag through a one-cycle response pulse.

---
 rtl/mau_pkg.sv | 20 ++
 rtl/mau_lane.sv | 39 +++
 rtl/mem_access_unit.sv | 102 ++++++++++
 tb/tb_mem_access_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared types and helpers for the data-RAM load/store front end.
package mau_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MERGE_RD, WRITE, RESP} state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Size 11 is illegal and always faults.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/mau_lane.sv
// Byte/half lane extraction with sign/zero extension, and sub-word merge
// into a RAM word. Shared by the load and read-modify-write paths.
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;

  always_comb begin
    byte_v  = word_i[{lane_i, 3'b000} +: 8];
    half_v  = lane_i[1] ? word_i[31:16] : word_i[15:0];
    sx      = 1'b0;
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SZ_B: begin
        sx     = ~unsigned_i & byte_v[7];
        load_o = {{24{sx}}, byte_v};
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        sx     = ~unsigned_i & half_v[15];
        load_o = {{16{sx}}, half_v};
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-wide data RAM: one request at a time,
// sub-word stores as read-modify-write, one-cycle response pulse.
module mem_access_unit
  import mau_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_d,
  output logic        ram_we,
  input  logic [31:0] ram_q
);
  state_e      state_q, state_d;
  logic        we_q, uns_q, mis_q;
  logic [1:0]  size_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, merge_q, rdata_q;
  logic [31:0] lane_load, lane_merge;
  logic        accept, fault, in_resp;

  // Upper address bits are dropped: the RAM aliases every 4 KiB.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:12];

  assign accept = req_valid && (state_q == IDLE);
  assign fault  = misaligned(req_size, req_addr[1:0]);

  mau_lane u_lane (
    .word_i     (ram_q),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (fault)              state_d = RESP;
        else if (!req_we)       state_d = LOAD;
        else if (req_size == SZ_W) state_d = WRITE;
        else                    state_d = MERGE_RD;
      end
      LOAD:     state_d = RESP;
      MERGE_RD: state_d = WRITE;
      WRITE:    state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr[11:0];
        wdata_q <= req_wdata;
        mis_q   <= fault;
        rdata_q <= '0;
      end
      if (state_q == LOAD)     rdata_q <= lane_load;
      if (state_q == MERGE_RD) merge_q <= lane_merge;
    end
  end

  // Reset gates the RAM strobe and response combinationally so an aborted
  // access leaves no trace, even in the cycle reset is raised.
  assign in_resp    = (state_q == RESP) && !rst;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = in_resp;
  assign resp_rdata = in_resp ? rdata_q : '0;
  assign misalign   = in_resp && mis_q;
  assign ram_addr   = addr_q[11:2];
  assign ram_we     = (state_q == WRITE) && !rst && we_q;
  assign ram_d      = (state_q == WRITE) ? ((size_q == SZ_W) ? wdata_q : merge_q) : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a combinational-read RAM model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, misalign, ram_we;
  logic [31:0] resp_rdata, ram_d, ram_q;
  logic [9:0]  ram_addr;

  logic [31:0] mem [0:1023];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  assign ram_q = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign(misalign), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // One request; observes 5 cycles after the accept edge (cycle 1 = N+1).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int rc, output logic [31:0] rd, output logic mis,
                        output int wc, output int wcyc, output logic [9:0] wa);
    @(negedge clk);
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    rc = 0; rd = '0; mis = 1'b0; wc = 0; wcyc = 0; wa = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (ram_we) begin wc++; wcyc = c; wa = ram_addr; end
      if (resp_valid && rc == 0) begin rc = c; rd = resp_rdata; mis = misalign; end
    end
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] exp);
    int rc, wc, wcyc; logic [31:0] rd; logic mis; logic [9:0] wa;
    do_req(1'b0, sz, uns, a, 32'h0, rc, rd, mis, wc, wcyc, wa);
    chk({tag, "_cyc"}, rc, 2);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_mis"}, {31'b0, mis}, 0);
    chk({tag, "_nowe"}, wc, 0);
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd, input int exp_rc, input logic [9:0] w,
                    input logic [31:0] exp_word);
    int rc, wc, wcyc; logic [31:0] rd; logic mis; logic [9:0] wa;
    do_req(1'b1, sz, 1'b0, a, wd, rc, rd, mis, wc, wcyc, wa);
    chk({tag, "_cyc"}, rc, exp_rc);
    chk({tag, "_wecnt"}, wc, 1);
    chk({tag, "_wecyc"}, wcyc, exp_rc - 1);
    chk({tag, "_weaddr"}, {22'b0, wa}, {22'b0, w});
    chk({tag, "_rdata0"}, rd, 0);
    chk({tag, "_mem"}, mem[w], exp_word);
  endtask

  task automatic flt(input string tag, input logic we, input logic [1:0] sz,
                     input logic [31:0] a);
    int rc, wc, wcyc; logic [31:0] rd; logic mis; logic [9:0] wa;
    do_req(we, sz, 1'b0, a, 32'hFFFF_FFFF, rc, rd, mis, wc, wcyc, wa);
    chk({tag, "_cyc"}, rc, 1);
    chk({tag, "_mis"}, {31'b0, mis}, 1);
    chk({tag, "_rdata"}, rd, 0);
    chk({tag, "_nowe"}, wc, 0);
  endtask

  // Reset raised in cycle N+1 of a store; checks the abort leaves no trace.
  task automatic abort_st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [9:0] w,
                          input logic [31:0] old);
    int nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 chk({tag, "_we_in_rst"}, {31'b0, ram_we}, 0);
    chk({tag, "_resp_in_rst"}, {31'b0, resp_valid}, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk({tag, "_ready"}, {31'b0, req_ready}, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || ram_we) nresp++;
    end
    chk({tag, "_noresp"}, nresp, 0);
    chk({tag, "_mem"}, mem[w], old);
  endtask

  initial begin
    int nresp;
    logic [7:0] rdy_pat, resp_pat;
    logic [31:0] last_rd;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_misalign", {31'b0, misalign}, 0);
    chk("rst_ram_we", {31'b0, ram_we}, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_ram_addr", {22'b0, ram_addr}, 0);
    @(negedge clk) rst = 1'b0;

    st("pre_w4", 2'b10, 32'h010, 32'h8899_AABB, 2, 10'h004, 32'h8899_AABB);
    ld("lb_s_012", 2'b00, 1'b0, 32'h012, 32'hFFFF_FF99);
    ld("lbu_013", 2'b00, 1'b1, 32'h013, 32'h0000_0088);
    ld("lb_s_010", 2'b00, 1'b0, 32'h010, 32'hFFFF_FFBB);
    ld("lhu_012", 2'b01, 1'b1, 32'h012, 32'h0000_8899);
    ld("lh_s_010", 2'b01, 1'b0, 32'h010, 32'hFFFF_AABB);
    ld("lw_wrap", 2'b10, 1'b0, 32'h1000_0010, 32'h8899_AABB);

    st("sw_020", 2'b10, 32'h020, 32'hDEAD_BEEF, 2, 10'h008, 32'hDEAD_BEEF);
    st("sw_pre8", 2'b10, 32'h020, 32'h1122_3344, 2, 10'h008, 32'h1122_3344);
    st("sb_021", 2'b00, 32'h021, 32'hFFFF_FFA5, 3, 10'h008, 32'h1122_A544);
    st("sh_022", 2'b01, 32'h022, 32'h1234_BEEF, 3, 10'h008, 32'hBEEF_A544);
    ld("lw_8", 2'b10, 1'b0, 32'h020, 32'hBEEF_A544);

    flt("f_lw_002", 1'b0, 2'b10, 32'h002);
    flt("f_sh_003", 1'b1, 2'b01, 32'h003);
    flt("f_sz11", 1'b0, 2'b11, 32'h000);
    chk("f_mem4_intact", mem[4], 32'h8899_AABB);

    abort_st("ab_sb", 2'b00, 32'h021, 32'h0000_0077, 10'h008, 32'hBEEF_A544);
    abort_st("ab_sw", 2'b10, 32'h020, 32'h5555_5555, 10'h008, 32'hBEEF_A544);

    // Held req_valid: accepts only in IDLE, i.e. every third edge for loads.
    rdy_pat = '0; resp_pat = '0; nresp = 0; last_rd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h010;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rdy_pat[c] = req_ready;
      resp_pat[c] = resp_valid;
      if (resp_valid) begin nresp++; last_rd = resp_rdata; end
      if (c == 6) req_valid = 1'b0;
    end
    chk("b2b_ready_pat", {24'b0, rdy_pat}, 32'h48);
    chk("b2b_resp_pat", {24'b0, resp_pat}, 32'h24);
    chk("b2b_nresp", nresp, 2);
    chk("b2b_data", last_rd, 32'h8899_AABB);
    repeat (4) @(negedge clk);
    chk("b2b_idle", {31'b0, req_ready}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
